johnson_seq_checker: RTL

Receive-side checker for the 3-bit six-state sequence code (000→001→011→111→110→100→000) produced by our sequence generator. Samples the code stream, recovers the phase index and one-hot slot, acquires lock after a run of correct transitions, and flags illegal codes and sequence breaks with a saturating error counter. Sits at the far end of the generator's code bus, in the same clock domain.

---
 rtl/johnson_seq_checker.sv | 133 +++++++++++++
 1 files changed

// File: rtl/johnson_seq_checker.sv
// johnson_seq_checker: receive-side checker for the six-state sequence
// code; recovers phase, acquires lock and counts sequence errors.
module johnson_seq_checker #(
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [2:0]       in_code,
    input  logic             err_clr,
    output logic [2:0]       phase,
    output logic [5:0]       onehot,
    output logic             locked,
    output logic             err_pulse,
    output logic             illegal,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

    localparam logic [ERR_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       LOCK_RUN = 4'(LOCK_CNT);

    state_t           state, state_nxt;
    logic [2:0]       last, last_nxt;
    logic [3:0]       run, run_nxt;
    logic [2:0]       idx, succ, phase_nxt;
    logic             legal, is_succ;
    logic             err_nxt, ill_nxt, locked_nxt;
    logic [ERR_W-1:0] cnt_nxt;

    always_comb begin
        idx   = 3'd0;
        legal = 1'b1;
        unique case (1'b1)
            (in_code == 3'b000): idx = 3'd0;
            (in_code == 3'b001): idx = 3'd1;
            (in_code == 3'b011): idx = 3'd2;
            (in_code == 3'b111): idx = 3'd3;
            (in_code == 3'b110): idx = 3'd4;
            (in_code == 3'b100): idx = 3'd5;
            default:             legal = 1'b0;
        endcase
    end

    assign succ    = (last == 3'd5) ? 3'd0 : last + 3'd1;
    assign is_succ = (idx == succ);

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        run_nxt   = run;
        phase_nxt = phase;
        err_nxt   = 1'b0;
        ill_nxt   = 1'b0;
        if (in_valid) begin
            if (legal) phase_nxt = idx;
            else       ill_nxt   = 1'b1;
            case (state)
                HUNT: begin
                    if (legal) begin
                        state_nxt = SYNC;
                        last_nxt  = idx;
                        run_nxt   = 4'd0;
                    end
                end
                SYNC: begin
                    if (!legal) begin
                        state_nxt = HUNT;
                    end else if (is_succ) begin
                        last_nxt = idx;
                        run_nxt  = run + 4'd1;
                        if (run + 4'd1 == LOCK_RUN) state_nxt = LOCK;
                    end else begin
                        last_nxt = idx;
                        run_nxt  = 4'd0;
                    end
                end
                LOCK: begin
                    if (!legal) begin
                        state_nxt = HUNT;
                        err_nxt   = 1'b1;
                    end else if (is_succ) begin
                        last_nxt = idx;
                    end else begin
                        state_nxt = SYNC;
                        last_nxt  = idx;
                        run_nxt   = 4'd0;
                        err_nxt   = 1'b1;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // clear wins over a same-cycle increment
    always_comb begin
        cnt_nxt = err_cnt;
        if (err_clr)
            cnt_nxt = '0;
        else if (err_nxt && err_cnt != CNT_MAX)
            cnt_nxt = err_cnt + 1'b1;
    end

    assign locked_nxt = (state_nxt == LOCK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            last      <= 3'd0;
            run       <= 4'd0;
            phase     <= 3'd0;
            onehot    <= 6'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            illegal   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            run       <= run_nxt;
            phase     <= phase_nxt;
            onehot    <= locked_nxt ? (6'b100000 >> phase_nxt) : 6'd0;
            locked    <= locked_nxt;
            err_pulse <= err_nxt;
            illegal   <= ill_nxt;
            err_cnt   <= cnt_nxt;
        end
    end

endmodule
